// File: rtl/buzzer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_scheduler
// Brief    : Priority sequencer for the piezo buzzer (alarm > chime > click)
//            producing timed beep/gap patterns and a square-wave tone.
//            Optional macro ALARM_TIMEOUT_EN stops the alarm after
//            ALARM_MAX_BEEPS beeps and parks in a silent ALARM_DONE state.
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_scheduler #(
    parameter int TICK_DIV        = 50000,
    parameter int TONE_HALF       = 12500,
    parameter int BEEP_TICKS      = 200,
    parameter int GAP_TICKS       = 200,
    parameter int CHIME_BEEPS     = 2,
    parameter int CLICK_TICKS     = 20,
    parameter int ALARM_MAX_BEEPS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_req,
    input  logic       chime_req_pulse,
    input  logic       click_req_pulse,
    input  logic       mute,
    output logic       buzzer_out,
    output logic       busy,
    output logic [1:0] active_src
);

    localparam int c_PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_TONE_W    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int c_MAX_TICKS0 = (BEEP_TICKS > GAP_TICKS) ? BEEP_TICKS : GAP_TICKS;
    localparam int c_MAX_TICKS = (c_MAX_TICKS0 > CLICK_TICKS) ? c_MAX_TICKS0 : CLICK_TICKS;
    localparam int c_TICK_W    = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS) : 1;
    localparam int c_MAX_BEEPS = (CHIME_BEEPS > ALARM_MAX_BEEPS) ? CHIME_BEEPS : ALARM_MAX_BEEPS;
    localparam int c_BEEP_W    = $clog2(c_MAX_BEEPS + 1);

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_TONE_W-1:0]  c_TONE_LAST  = c_TONE_W'(TONE_HALF - 1);
    localparam logic [c_TICK_W-1:0]  c_BEEP_LAST  = c_TICK_W'(BEEP_TICKS - 1);
    localparam logic [c_TICK_W-1:0]  c_GAP_LAST   = c_TICK_W'(GAP_TICKS - 1);
    localparam logic [c_TICK_W-1:0]  c_CLICK_LAST = c_TICK_W'(CLICK_TICKS - 1);
    localparam logic [c_BEEP_W-1:0]  c_CHIME_NUM  = c_BEEP_W'(CHIME_BEEPS);
`ifdef ALARM_TIMEOUT_EN
    localparam logic [c_BEEP_W-1:0]  c_ALARM_NUM  = c_BEEP_W'(ALARM_MAX_BEEPS);
`endif

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLICK      = 3'd1,
        S_CHIME_ON   = 3'd2,
        S_CHIME_GAP  = 3'd3,
        S_ALARM_ON   = 3'd4,
        S_ALARM_GAP  = 3'd5,
        S_ALARM_DONE = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [c_PRESC_W-1:0]  presc_q, presc_d;
    logic [c_TICK_W-1:0]   tick_q, tick_d;
    logic [c_TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic                  tone_q, tone_d;
    logic [c_BEEP_W-1:0]   beep_q, beep_d;
    logic                  buzzer_out_q, buzzer_out_d;
    logic                  busy_q, busy_d;
    logic [1:0]            active_src_q, active_src_d;

    logic [c_TICK_W-1:0]   w_dur_last;
    logic [c_BEEP_W-1:0]   w_beep_inc;
    logic                  w_presc_wrap;
    logic                  w_phase_end;
    logic                  w_tone_state;

    always_comb begin
        case (state_q)
            S_CLICK:                 w_dur_last = c_CLICK_LAST;
            S_CHIME_ON, S_ALARM_ON:  w_dur_last = c_BEEP_LAST;
            S_CHIME_GAP, S_ALARM_GAP: w_dur_last = c_GAP_LAST;
            default:                 w_dur_last = '0;
        endcase
        w_presc_wrap = (presc_q == c_PRESC_LAST);
        w_phase_end  = w_presc_wrap && (tick_q == w_dur_last);
        w_beep_inc   = (&beep_q) ? beep_q : beep_q + 1'b1;

        state_d = state_q;
        beep_d  = beep_q;
        case (state_q)
            S_IDLE: begin
                if (alarm_req)            state_d = S_ALARM_ON;
                else if (chime_req_pulse) state_d = S_CHIME_ON;
                else if (click_req_pulse) state_d = S_CLICK;
            end
            S_CLICK: begin
                if (alarm_req)            state_d = S_ALARM_ON;
                else if (chime_req_pulse) state_d = S_CHIME_ON;
                else if (w_phase_end)     state_d = S_IDLE;
            end
            S_CHIME_ON: begin
                if (alarm_req) begin
                    state_d = S_ALARM_ON;
                    beep_d  = '0;
                end else if (w_phase_end) begin
                    beep_d  = w_beep_inc;
                    state_d = (w_beep_inc == c_CHIME_NUM) ? S_IDLE : S_CHIME_GAP;
                end
            end
            S_CHIME_GAP: begin
                if (alarm_req) begin
                    state_d = S_ALARM_ON;
                    beep_d  = '0;
                end else if (w_phase_end) begin
                    state_d = S_CHIME_ON;
                end
            end
            S_ALARM_ON: begin
                if (!alarm_req) begin
                    state_d = S_IDLE;
                end else if (w_phase_end) begin
`ifdef ALARM_TIMEOUT_EN
                    beep_d  = w_beep_inc;
                    state_d = (w_beep_inc == c_ALARM_NUM) ? S_ALARM_DONE : S_ALARM_GAP;
`else
                    state_d = S_ALARM_GAP;
`endif
                end
            end
            S_ALARM_GAP: begin
                if (!alarm_req)       state_d = S_IDLE;
                else if (w_phase_end) state_d = S_ALARM_ON;
            end
`ifdef ALARM_TIMEOUT_EN
            S_ALARM_DONE: begin
                if (!alarm_req) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Every sequence starts its beep count from zero.
        if (state_d == S_IDLE || state_d == S_CLICK) beep_d = '0;

        w_tone_state = (state_d == S_CLICK) || (state_d == S_CHIME_ON) ||
                       (state_d == S_ALARM_ON);

        // Prescaler, tick and tone all restart on state entry so phases are exact.
        if (state_d != state_q || state_d == S_IDLE || state_d == S_ALARM_DONE) begin
            presc_d = '0;
            tick_d  = '0;
        end else begin
            presc_d = w_presc_wrap ? '0 : presc_q + 1'b1;
            tick_d  = (w_presc_wrap && !(&tick_q)) ? tick_q + 1'b1 : tick_q;
        end

        if (!w_tone_state) begin
            tone_d     = 1'b0;
            tone_cnt_d = '0;
        end else if (state_d != state_q) begin
            tone_d     = 1'b1;
            tone_cnt_d = '0;
        end else if (tone_cnt_q == c_TONE_LAST) begin
            tone_d     = ~tone_q;
            tone_cnt_d = '0;
        end else begin
            tone_d     = tone_q;
            tone_cnt_d = tone_cnt_q + 1'b1;
        end

        buzzer_out_d = tone_d & ~mute;
        busy_d       = (state_d != S_IDLE);
        case (state_d)
            S_CLICK:                  active_src_d = 2'd1;
            S_CHIME_ON, S_CHIME_GAP:  active_src_d = 2'd2;
            S_ALARM_ON, S_ALARM_GAP,
            S_ALARM_DONE:             active_src_d = 2'd3;
            default:                  active_src_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            tick_q       <= '0;
            tone_cnt_q   <= '0;
            tone_q       <= 1'b0;
            beep_q       <= '0;
            buzzer_out_q <= 1'b0;
            busy_q       <= 1'b0;
            active_src_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            tone_cnt_q   <= tone_cnt_d;
            tone_q       <= tone_d;
            beep_q       <= beep_d;
            buzzer_out_q <= buzzer_out_d;
            busy_q       <= busy_d;
            active_src_q <= active_src_d;
        end
    end

    assign buzzer_out = buzzer_out_q;
    assign busy       = busy_q;
    assign active_src = active_src_q;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_buzzer_scheduler
// Brief    : Directed self-checking bench for buzzer_scheduler with small
//            timing parameters; expectations depend on ALARM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alarm_req = 1'b0;
    logic       chime_req_pulse = 1'b0;
    logic       click_req_pulse = 1'b0;
    logic       mute = 1'b0;
    logic       buzzer_out;
    logic       busy;
    logic [1:0] active_src;

    int checks = 0;
    int errors = 0;

    buzzer_scheduler #(
        .TICK_DIV(4), .TONE_HALF(2), .BEEP_TICKS(3), .GAP_TICKS(2),
        .CHIME_BEEPS(2), .CLICK_TICKS(1), .ALARM_MAX_BEEPS(3)
    ) u_dut (
        .clk(clk), .rst(rst), .alarm_req(alarm_req),
        .chime_req_pulse(chime_req_pulse), .click_req_pulse(click_req_pulse),
        .mute(mute), .buzzer_out(buzzer_out), .busy(busy), .active_src(active_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs();
        return {buzzer_out, busy, active_src};
    endfunction

    function automatic logic [3:0] ex(input bit bz, input bit b, input logic [1:0] s);
        return {bz, b, s};
    endfunction

    // Tone inside an ON phase: 1,1,0,0 repeating from the phase's first cycle.
    function automatic bit tone_at(input int pos);
        return ((pos / 2) % 2) == 0;
    endfunction

    task automatic run_chime(input string tag, input bit m);
        int p;
        bit on;
        mute = m;
        chime_req_pulse = 1'b1;
        step();
        chime_req_pulse = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            on = (k <= 12) || (k > 20);
            p  = (k <= 12) ? k - 1 : k - 21;
            check(tag, obs(), ex(on && !m && tone_at(p), 1'b1, 2'd2));
            step();
        end
        check({tag, "_end"}, obs(), ex(1'b0, 1'b0, 2'd0));
        mute = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy; i++) step();
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int  p;
        bit  on;
        logic [3:0] e;

        // Reset
        step(); step();
        check("reset", obs(), ex(1'b0, 1'b0, 2'd0));
        rst = 1'b0;
        step();
        check("idle", obs(), ex(1'b0, 1'b0, 2'd0));

        // Chime, then the same chime muted
        run_chime("chime", 1'b0);
        step();
        run_chime("chime_mute", 1'b1);
        step();

        // Click with a second click on cycle 2 (ignored)
        click_req_pulse = 1'b1; step(); click_req_pulse = 1'b0;
        check("click_c1", obs(), ex(1'b1, 1'b1, 2'd1));
        step();
        check("click_c2", obs(), ex(1'b1, 1'b1, 2'd1));
        click_req_pulse = 1'b1; step(); click_req_pulse = 1'b0;
        check("click_c3", obs(), ex(1'b0, 1'b1, 2'd1));
        step();
        check("click_c4", obs(), ex(1'b0, 1'b1, 2'd1));
        step();
        check("click_end", obs(), ex(1'b0, 1'b0, 2'd0));

        // Click pre-empted by chime on cycle 2
        click_req_pulse = 1'b1; step(); click_req_pulse = 1'b0;
        step();
        check("clk_pre_c2", obs(), ex(1'b1, 1'b1, 2'd1));
        chime_req_pulse = 1'b1; step(); chime_req_pulse = 1'b0;
        check("clk_pre_chime", obs(), ex(1'b1, 1'b1, 2'd2));
        wait_idle(40);

        // Alarm rises mid-chime, falls mid-ON
        chime_req_pulse = 1'b1; step(); chime_req_pulse = 1'b0;
        for (int i = 0; i < 5; i++) step();
        alarm_req = 1'b1; step();
        check("alarm_pre_c1", obs(), ex(1'b1, 1'b1, 2'd3));
        step();
        check("alarm_pre_c2", obs(), ex(1'b1, 1'b1, 2'd3));
        alarm_req = 1'b0; step();
        check("alarm_fall", obs(), ex(1'b0, 1'b0, 2'd0));
        step();

        // Alarm held high
        alarm_req = 1'b1; step();
        for (int k = 1; k <= 64; k++) begin
            p  = (k - 1) % 20;
            on = p < 12;
            e  = ex(on && tone_at(p), 1'b1, 2'd3);
`ifdef ALARM_TIMEOUT_EN
            if (k > 52) e = ex(1'b0, 1'b1, 2'd3);
`endif
            check("alarm_hold", obs(), e);
            step();
        end
        alarm_req = 1'b0; step();
        check("alarm_release", obs(), ex(1'b0, 1'b0, 2'd0));
        step();

        // Reset mid-alarm with alarm_req still high
        alarm_req = 1'b1; step(); step(); step();
        rst = 1'b1; step();
        check("rst_mid_alarm", obs(), ex(1'b0, 1'b0, 2'd0));
        rst = 1'b0; step();
        check("alarm_after_rst", obs(), ex(1'b1, 1'b1, 2'd3));
        alarm_req = 1'b0; step();
        check("final_idle", obs(), ex(1'b0, 1'b0, 2'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
